// File: rtl/pwm_module.sv
// Counter-compare PWM generator with a clock-enable prescaler and a single clock.
// Define PWM_SHADOW_EN to latch duty_cycle only at period boundaries.
module pwm_module #(
  parameter int unsigned WIDTH = 4,
  parameter int unsigned DIV   = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] duty_cycle,
  output logic             pwm_out
);

  localparam logic [15:0] PRE_LAST = 16'(DIV - 1);

  logic [15:0]      pre_cnt;
  logic             tick;
  logic [WIDTH-1:0] cnt;
  logic [WIDTH-1:0] duty_eff;

  // With DIV=1 PRE_LAST is 0, so pre_cnt stays at 0 and tick is constant.
  assign tick = (pre_cnt == PRE_LAST);

  always_ff @(posedge clk) begin
    if (rst) begin
      pre_cnt <= '0;
    end else if (tick) begin
      pre_cnt <= '0;
    end else begin
      pre_cnt <= pre_cnt + 16'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
    end else if (tick) begin
      cnt <= cnt + WIDTH'(1);
    end
  end

`ifdef PWM_SHADOW_EN
  localparam logic [WIDTH-1:0] CNT_LAST = '1;

  logic [WIDTH-1:0] duty_act;
  logic             period_start;

  assign period_start = tick && (cnt == CNT_LAST);

  always_ff @(posedge clk) begin
    if (rst) begin
      duty_act <= '0;
    end else if (period_start) begin
      duty_act <= duty_cycle;
    end
  end

  assign duty_eff = duty_act;
`else
  assign duty_eff = duty_cycle;
`endif

  // Compare runs every clk so duty changes land within one cycle, not one tick.
  always_ff @(posedge clk) begin
    if (rst) begin
      pwm_out <= 1'b0;
    end else begin
      pwm_out <= (cnt < duty_eff);
    end
  end

endmodule

// File: tb/tb_pwm_module.sv
// Directed bench for pwm_module: default build (WIDTH=4, DIV=2) and a DIV=1 instance.
// Expected values follow PWM_SHADOW_EN when the bench is built with it.
module tb_pwm_module;

  logic       clk;
  logic       rst;
  logic [3:0] duty;
  logic       pwm;
  logic       rst1;
  logic [3:0] duty1;
  logic       pwm1;

  int unsigned checks;
  int unsigned errors;

`ifdef PWM_SHADOW_EN
  localparam bit SHADOW = 1'b1;
`else
  localparam bit SHADOW = 1'b0;
`endif

  pwm_module #(.WIDTH(4), .DIV(2)) dut (
    .clk       (clk),
    .rst       (rst),
    .duty_cycle(duty),
    .pwm_out   (pwm)
  );

  pwm_module #(.WIDTH(4), .DIV(1)) dut1 (
    .clk       (clk),
    .rst       (rst1),
    .duty_cycle(duty1),
    .pwm_out   (pwm1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]  duty;
    int unsigned high;
  } vec_t;

  vec_t vecs[5];

  task automatic check(input string name, input int unsigned act, input int unsigned exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset(input logic [3:0] d);
    rst  = 1'b1;
    duty = d;
    for (int i = 0; i < 3; i++) begin
      step();
      check("reset_low", pwm, 0);
    end
    rst = 1'b0;
  endtask

  initial begin
    int unsigned cnt_a;
    int unsigned cnt_b;
    int unsigned s_first;
    int unsigned s_last;
    bit s[1:96];

    checks = 0;
    errors = 0;
    rst    = 1'b1;
    duty   = 4'h0;
    rst1   = 1'b1;
    duty1  = 4'h0;

    // Steady-state high time per 32-cycle period at DIV=2 is 2*duty.
    vecs[0] = '{duty: 4'h0, high: 0};
    vecs[1] = '{duty: 4'h5, high: 10};
    vecs[2] = '{duty: 4'hF, high: 30};
    vecs[3] = '{duty: 4'h1, high: 2};
    vecs[4] = '{duty: 4'h8, high: 16};

    for (int v = 0; v < 5; v++) begin
      do_reset(vecs[v].duty);
      check("release_low", pwm, 0);
      cnt_a = 0;
      for (int k = 1; k <= 32; k++) begin
        step();
        cnt_a += pwm;
      end
      cnt_b = 0;
      for (int k = 33; k <= 64; k++) begin
        step();
        cnt_b += pwm;
        if (k == 33) s_first = pwm;
        if (k == 64) s_last = pwm;
      end
      check("first_period_high", cnt_a, SHADOW ? 0 : vecs[v].high);
      check("period_high", cnt_b, vecs[v].high);
      check("period_first_sample", s_first, (vecs[v].duty != 0) ? 1 : 0);
      check("period_last_sample", s_last, 0);
    end

    // Duty 0 for three full periods: never high, including across wraps.
    do_reset(4'h0);
    cnt_a = 0;
    for (int k = 1; k <= 96; k++) begin
      step();
      cnt_a += pwm;
    end
    check("duty0_96", cnt_a, 0);

    // Duty 2 -> A just after cnt becomes 6 in the second period (edge 44).
    do_reset(4'h2);
    for (int k = 1; k <= 96; k++) begin
      step();
      s[k] = pwm;
      if (k == 44) duty = 4'hA;
    end
    cnt_a = 0;
    cnt_b = 0;
    for (int k = 33; k <= 64; k++) cnt_a += s[k];
    for (int k = 65; k <= 96; k++) cnt_b += s[k];
    check("change_cur_period", cnt_a, SHADOW ? 4 : 12);
    check("change_resume", s[45], SHADOW ? 0 : 1);
    check("change_cnt9_high", s[52], SHADOW ? 0 : 1);
    check("change_cnt10_low", s[53], 0);
    check("change_next_period", cnt_b, 20);

    // DIV=1: reset asserted at cnt=3 forces the output low on the next edge.
    rst1  = 1'b1;
    duty1 = 4'hA;
    step();
    step();
    check("div1_reset_low", pwm1, 0);
    rst1 = 1'b0;
    for (int k = 1; k <= 3; k++) step();
    check("div1_before_abort", pwm1, SHADOW ? 0 : 1);
    rst1 = 1'b1;
    step();
    check("div1_abort_low", pwm1, 0);
    rst1 = 1'b0;
    cnt_a = 0;
    for (int k = 1; k <= 16; k++) begin
      step();
      cnt_a += pwm1;
      if (k == 16) s_last = pwm1;
    end
    cnt_b = 0;
    for (int k = 17; k <= 32; k++) begin
      step();
      cnt_b += pwm1;
      if (k == 17) s_first = pwm1;
    end
    check("div1_first_period", cnt_a, SHADOW ? 0 : 10);
    check("div1_period_end_low", s_last, 0);
    check("div1_second_period", cnt_b, 10);
    check("div1_second_start", s_first, 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
